// File: rtl/sha_pkg.sv
// Shared SHA-256 controller definitions: FSM states, block geometry and the initial hash value.
package sha_pkg;

    localparam int unsigned ROUNDS_DEFAULT    = 64;
    localparam int unsigned BLK_WORDS_DEFAULT = 16;
    localparam int unsigned ROUND_W           = 6;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StUpdate
    } sha_state_e;

    // H0 occupies the most significant word.
    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] iv_word(input int unsigned idx);
        logic [255:0] iv_v;
        iv_v = IV;
        return iv_v[255 - 32 * idx -: 32];
    endfunction

endpackage

// File: rtl/sha_ctrl.sv
// SHA-256 block controller: forwards message words to the schedule, sequences the
// compression rounds and pulses hash init/update/digest strobes.
module sha_ctrl
    import sha_pkg::*;
#(
    parameter int unsigned ROUNDS    = ROUNDS_DEFAULT,
    parameter int unsigned BLK_WORDS = BLK_WORDS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        in_data,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    output logic               in_ready,
    output logic [31:0]        M_o,
    output logic               M_dv_o,
    input  logic               W_dv_i,
    output logic [ROUND_W-1:0] round_o,
    output logic               round_en_o,
    output logic               hash_init_o,
    output logic               hash_update_o,
    output logic               digest_valid_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int unsigned WCNT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [WCNT_W-1:0]  LAST_WORD  = WCNT_W'(BLK_WORDS - 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS - 1);

    sha_state_e         state_q, state_d;
    logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ROUND_W-1:0] round_cnt_q, round_cnt_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               hash_update_q, hash_update_d;
    logic               digest_valid_q, digest_valid_d;

    logic accept;
    logic round_en;

    assign accept   = in_valid & in_ready_q;
    assign round_en = W_dv_i & ((state_q == StLoad) | (state_q == StRun));

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        round_cnt_d = round_cnt_q;
        last_d      = last_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (W_dv_i) begin
                    err_d = 1'b1;
                end
                if (accept) begin
                    // A missing first flag is flagged but the word still opens a message.
                    if (!in_first) begin
                        err_d = 1'b1;
                    end
                    last_d      = in_last;
                    word_cnt_d  = WCNT_W'(1);
                    round_cnt_d = '0;
                    state_d     = StLoad;
                end
            end
            StLoad, StRun: begin
                if (accept) begin
                    if (word_cnt_q == '0) begin
                        last_d = in_last;
                    end
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = StRun;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
                // The final round wins over the load transition.
                if (round_en) begin
                    if (round_cnt_q == LAST_ROUND) begin
                        state_d = StUpdate;
                    end else begin
                        round_cnt_d = round_cnt_q + 1'b1;
                    end
                end
            end
            StUpdate: begin
                if (W_dv_i) begin
                    err_d = 1'b1;
                end
                word_cnt_d  = '0;
                round_cnt_d = '0;
                state_d     = last_q ? StIdle : StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobes decoded from the next state so they leave the flops glitch-free.
    always_comb begin
        in_ready_d     = (state_d == StIdle) | (state_d == StLoad);
        busy_d         = (state_d != StIdle);
        hash_update_d  = (state_d == StUpdate);
        digest_valid_d = (state_d == StUpdate) & last_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            word_cnt_q     <= '0;
            round_cnt_q    <= '0;
            last_q         <= 1'b0;
            err_q          <= 1'b0;
            in_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            hash_update_q  <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            round_cnt_q    <= round_cnt_d;
            last_q         <= last_d;
            err_q          <= err_d;
            in_ready_q     <= in_ready_d;
            busy_q         <= busy_d;
            hash_update_q  <= hash_update_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign M_o            = in_data;
    assign M_dv_o         = accept;
    assign hash_init_o    = accept & (state_q == StIdle);
    assign round_o        = round_cnt_q;
    assign round_en_o     = round_en;
    assign hash_update_o  = hash_update_q;
    assign digest_valid_o = digest_valid_q;
    assign busy_o         = busy_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_sha_ctrl.sv
// Directed bench for sha_ctrl: table-driven "abc" block plus multi-block, gap, reset and error cases.
module tb_sha_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid, in_first, in_last, in_ready;
    logic [31:0] M_o;
    logic        M_dv_o, W_dv_i;
    logic [5:0]  round_o;
    logic        round_en_o, hash_init_o, hash_update_o, digest_valid_o, busy_o, err_o;

    sha_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_first       (in_first),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .M_o            (M_o),
        .M_dv_o         (M_dv_o),
        .W_dv_i         (W_dv_i),
        .round_o        (round_o),
        .round_en_o     (round_en_o),
        .hash_init_o    (hash_init_o),
        .hash_update_o  (hash_update_o),
        .digest_valid_o (digest_valid_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int n_mdv = 0, n_init = 0, n_upd = 0, n_dig = 0, n_ren = 0;
    logic [31:0] mq [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (M_dv_o) begin
                n_mdv <= n_mdv + 1;
                mq.push_back(M_o);
            end
            if (hash_init_o)    n_init <= n_init + 1;
            if (hash_update_o)  n_upd  <= n_upd + 1;
            if (digest_valid_o) n_dig  <= n_dig + 1;
            if (round_en_o)     n_ren  <= n_ren + 1;
        end
    end

    typedef struct {
        logic        v, first, last, wdv;
        logic [31:0] data;
        logic        e_rdy, e_mdv, e_init, e_ren, e_busy;
        logic [5:0]  e_round;
    } vec_t;

    vec_t        tbl [21];
    logic [31:0] abc_w [16];
    logic [31:0] blk_w [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic f, input logic l, input logic wdv,
                                input logic [31:0] d, input logic rdy, input logic mdv,
                                input logic init, input logic ren, input logic busy,
                                input logic [5:0] rnd);
        vec_t r;
        r.v = v; r.first = f; r.last = l; r.wdv = wdv; r.data = d;
        r.e_rdy = rdy; r.e_mdv = mdv; r.e_init = init; r.e_ren = ren; r.e_busy = busy;
        r.e_round = rnd;
        return r;
    endfunction

    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle_end();
        cycle_end();
        rst = 1'b0;
        cycle_end();
    endtask

    task automatic send_block(input logic first, input logic last, input bit toggle,
                              input bit exp_init, input logic [31:0] w [16]);
        int i = 0;
        int cyc = 0;
        while (i < 16 && cyc < 64) begin
            bit v;
            v = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid = v; in_first = first; in_last = last; in_data = w[i];
            @(negedge clk);
            chk("blk_ready", in_ready, 1);
            chk("blk_mdv", M_dv_o, v);
            chk("blk_init", hash_init_o, (v && i == 0 && exp_init));
            if (v) chk("blk_m_o", M_o, w[i]);
            if (v && in_ready) i++;
            cycle_end();
            cyc++;
        end
        in_valid = 1'b0;
        if (i < 16) chk("blk_timeout", i, 16);
    endtask

    task automatic run_rounds(input int start, input int n);
        for (int t = start; t < start + n; t++) begin
            if (t % 10 == 5) begin
                W_dv_i = 1'b0;
                @(negedge clk);
                chk("gap_ren", round_en_o, 0);
                chk("gap_round", round_o, t);
                cycle_end();
            end
            W_dv_i = 1'b1;
            @(negedge clk);
            chk("rnd_en", round_en_o, 1);
            chk("rnd_idx", round_o, t);
            chk("rnd_ready", in_ready, 0);
            chk("rnd_busy", busy_o, 1);
            cycle_end();
        end
        W_dv_i = 1'b0;
    endtask

    task automatic check_update(input bit last);
        @(negedge clk);
        chk("upd_pulse", hash_update_o, 1);
        chk("upd_digest", digest_valid_o, last);
        chk("upd_busy", busy_o, 1);
        chk("upd_ready", in_ready, 0);
        cycle_end();
        @(negedge clk);
        chk("post_upd", hash_update_o, 0);
        chk("post_digest", digest_valid_o, 0);
        chk("post_busy", busy_o, !last);
        chk("post_ready", in_ready, 1);
        cycle_end();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s_mdv, s_init, s_upd, s_dig, s_ren;

        abc_w[0] = 32'h61626380;
        for (int k = 1; k < 15; k++) abc_w[k] = 32'h0;
        abc_w[15] = 32'h00000018;

        // LOAD of "abc" with one gap, then the first RUN cycles
        tbl[0] = mk(1, 1, 1, 0, abc_w[0], 1, 1, 1, 0, 0, 0);
        tbl[1] = mk(0, 1, 1, 0, 32'h0,    1, 0, 0, 0, 1, 0);
        for (int k = 1; k < 15; k++) tbl[k + 1] = mk(1, 0, 0, 0, abc_w[k], 1, 1, 0, 0, 1, 0);
        tbl[16] = mk(1, 0, 0, 0, abc_w[15],    1, 1, 0, 0, 1, 0);
        tbl[17] = mk(1, 0, 0, 0, 32'hdeadbeef, 0, 0, 0, 0, 1, 0);
        tbl[18] = mk(0, 0, 0, 1, 32'h0,        0, 0, 0, 1, 1, 0);
        tbl[19] = mk(0, 0, 0, 1, 32'h0,        0, 0, 0, 1, 1, 1);
        tbl[20] = mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 1, 2);

        rst = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = 32'h1234;
        W_dv_i = 1'b1;
        #3;
        chk("rst_mdv", M_dv_o, 0);
        chk("rst_init", hash_init_o, 0);
        chk("rst_ren", round_en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_upd", hash_update_o, 0);
        chk("rst_digest", digest_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_round", round_o, 0);
        in_valid = 1'b0; W_dv_i = 1'b0;
        cycle_end();
        rst = 1'b0;
        cycle_end();
        chk("rst_ready_after", in_ready, 1);
        chk("rst_busy_after", busy_o, 0);

        // "abc" single block
        s_mdv = n_mdv; s_init = n_init; s_upd = n_upd; s_dig = n_dig; s_ren = n_ren;
        for (int r = 0; r < 21; r++) begin
            in_valid = tbl[r].v; in_first = tbl[r].first; in_last = tbl[r].last;
            in_data = tbl[r].data; W_dv_i = tbl[r].wdv;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), in_ready, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_mdv", r), M_dv_o, tbl[r].e_mdv);
            chk($sformatf("tbl%0d_init", r), hash_init_o, tbl[r].e_init);
            chk($sformatf("tbl%0d_ren", r), round_en_o, tbl[r].e_ren);
            chk($sformatf("tbl%0d_busy", r), busy_o, tbl[r].e_busy);
            chk($sformatf("tbl%0d_round", r), round_o, tbl[r].e_round);
            if (tbl[r].e_mdv) chk($sformatf("tbl%0d_m_o", r), M_o, tbl[r].data);
            cycle_end();
        end
        in_valid = 1'b0; W_dv_i = 1'b0;
        run_rounds(2, 62);
        check_update(1'b1);
        chk("abc_mdv_cnt", n_mdv - s_mdv, 16);
        chk("abc_init_cnt", n_init - s_init, 1);
        chk("abc_ren_cnt", n_ren - s_ren, 64);
        chk("abc_upd_cnt", n_upd - s_upd, 1);
        chk("abc_dig_cnt", n_dig - s_dig, 1);

        // Two-block message
        s_init = n_init; s_upd = n_upd; s_dig = n_dig;
        for (int k = 0; k < 16; k++) blk_w[k] = 32'hA000_0000 + k;
        send_block(1'b1, 1'b0, 1'b0, 1'b1, blk_w);
        run_rounds(0, 64);
        check_update(1'b0);
        for (int k = 0; k < 16; k++) blk_w[k] = 32'hB000_0000 + k;
        send_block(1'b0, 1'b1, 1'b0, 1'b0, blk_w);
        run_rounds(0, 64);
        check_update(1'b1);
        chk("two_init_cnt", n_init - s_init, 1);
        chk("two_upd_cnt", n_upd - s_upd, 2);
        chk("two_dig_cnt", n_dig - s_dig, 1);
        chk("two_err", err_o, 0);

        // in_valid toggling every cycle during LOAD
        s_mdv = n_mdv;
        mq.delete();
        for (int k = 0; k < 16; k++) blk_w[k] = 32'h0101_0101 * (k + 1);
        send_block(1'b1, 1'b1, 1'b1, 1'b1, blk_w);
        chk("tog_mdv_cnt", n_mdv - s_mdv, 16);
        chk("tog_q_size", mq.size(), 16);
        for (int k = 0; k < 16 && k < mq.size(); k++) chk($sformatf("tog_word%0d", k), mq[k], blk_w[k]);
        run_rounds(0, 64);
        check_update(1'b1);

        // Asynchronous reset at round 30, then a fresh "abc"
        send_block(1'b1, 1'b1, 1'b0, 1'b1, abc_w);
        run_rounds(0, 30);
        W_dv_i = 1'b1;
        #1;
        chk("r30_ren_pre", round_en_o, 1);
        chk("r30_round_pre", round_o, 30);
        rst = 1'b1; in_valid = 1'b1;
        #1;
        chk("r30_ren", round_en_o, 0);
        chk("r30_round", round_o, 0);
        chk("r30_busy", busy_o, 0);
        chk("r30_mdv", M_dv_o, 0);
        chk("r30_upd", hash_update_o, 0);
        chk("r30_ready", in_ready, 0);
        cycle_end();
        rst = 1'b0; in_valid = 1'b0; W_dv_i = 1'b0;
        cycle_end();
        chk("r30_ready_after", in_ready, 1);
        s_dig = n_dig; s_ren = n_ren;
        send_block(1'b1, 1'b1, 1'b0, 1'b1, abc_w);
        run_rounds(0, 64);
        check_update(1'b1);
        chk("r30_dig_cnt", n_dig - s_dig, 1);
        chk("r30_ren_cnt", n_ren - s_ren, 64);

        // W_dv in IDLE: sticky error, no round
        W_dv_i = 1'b1;
        @(negedge clk);
        chk("idle_wdv_ren", round_en_o, 0);
        chk("idle_wdv_busy", busy_o, 0);
        cycle_end();
        W_dv_i = 1'b0;
        chk("idle_wdv_err", err_o, 1);
        for (int k = 0; k < 5; k++) cycle_end();
        chk("idle_wdv_sticky", err_o, 1);
        do_reset();
        chk("err_cleared", err_o, 0);

        // Accepted word in IDLE without in_first
        in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1; in_data = 32'h55;
        @(negedge clk);
        chk("nofirst_mdv", M_dv_o, 1);
        cycle_end();
        in_valid = 1'b0;
        chk("nofirst_err", err_o, 1);
        chk("nofirst_busy", busy_o, 1);
        do_reset();
        chk("nofirst_cleared", err_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
